multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Upstream control block for the RV32I datapath.
- Consumes opcode/funct3/funct7 from the instruction-field split and drives every datapath control input: reg_wr, sel_A, sel_B, wb_sel, ImmSrc, alu_op, br_type, ReadControl, WriteControl.
- Sequences each instruction over 2-4 cycles. Gates PC update and register/memory writes to the final phase, supports data-memory wait states, and traps on illegal opcodes.

Parameters:
- MEM_WAIT_EN, 1, 1 = honour mem_ready in MEM; 0 = MEM always lasts exactly one cycle.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7  in  7  instruction[31:25]
- mem_ready  in  1  data memory access complete
- pc_wr  out  1  PC register load enable
- reg_wr  out  1  register file write enable
- sel_A  out  1  0=PC, 1=RD1
- sel_B  out  1  0=RD2, 1=ImmExt
- wb_sel  out  2  0=PC+4, 1=ALUResult, 2=rdata
- ImmSrc  out  3  0=I, 1=S, 2=B, 3=U, 4=J
- alu_op  out  4  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 10 passB
- br_type  out  3  0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 7 always
- ReadControl  out  3  0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu
- WriteControl  out  3  0 none, 1 sb, 2 sh, 3 sw
- halted  out  1  illegal instruction trapped
- instret  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, EXEC, MEM, WB, TRAP. Reset (asynchronous) forces FETCH, instret=0, halted=0, and all control outputs 0.
- FETCH: opcode/funct3/funct7 are latched into internal IR fields; all control outputs are 0. Next state is EXEC, or TRAP if the opcode is not one of 0x33, 0x13, 0x03, 0x23, 0x63, 0x37, 0x17, 0x6F, 0x67.
- Decode is taken from the latched fields only. Input changes after FETCH have no effect.
- Static controls (sel_A, sel_B, ImmSrc, alu_op, wb_sel, br_type) are held stable from EXEC through the last state of the instruction.
- R-type: alu_op from funct3, with funct7[5] selecting sub/sra. I-ALU: funct7[5] is used only for srai.
- Path by class:
  - ALU, LUI, AUIPC: EXEC -> WB. reg_wr=1 and pc_wr=1 in WB. LUI uses alu_op passB, ImmSrc U. AUIPC uses sel_A=0, add.
  - JAL/JALR: EXEC -> WB. br_type=7 and wb_sel=0, with reg_wr=1 and pc_wr=1 in WB. JAL: sel_A=0, ImmSrc J. JALR: sel_A=1, ImmSrc I.
  - Branch: EXEC only. ImmSrc B, sel_A=0, sel_B=1, add; br_type from funct3 (000->1, 001->2, 100->3, 101->4, 110->5, 111->6). pc_wr=1 in EXEC, then return to FETCH. Latency is 2 cycles.
  - Load: EXEC -> MEM -> WB. ReadControl is asserted in MEM and WB. wb_sel=2; reg_wr=1 and pc_wr=1 in WB.
  - Store: EXEC -> MEM. WriteControl is nonzero only in the final MEM cycle (the cycle in which mem_ready=1); pc_wr=1 in that same cycle. No WB state.
- MEM: stays in MEM while mem_ready=0 and MEM_WAIT_EN=1, holding all outputs. There is no timeout.
- Illegal funct3 (load 3/6/7, store >=3, branch 2/3) -> TRAP on the EXEC->next transition. No writes occur.
- TRAP: all control outputs 0, halted=1. TRAP is left only by rst.
- reg_wr, pc_wr, and nonzero WriteControl are each asserted for exactly one cycle per instruction and never in FETCH.
- instret increments by 1 on every cycle with pc_wr=1 and wraps modulo 2^CNT_W.
- Reset mid-instruction: outputs drop to 0 immediately (asynchronously) and no partial write is committed after rst rises.

Test Plan:
- add x3,x1,x2 (0x002081B3): FETCH, EXEC, WB. reg_wr=1 and pc_wr=1 only in cycle 3; alu_op=0, wb_sel=1, sel_A=1, sel_B=0; instret 0->1.
- lw with mem_ready low for 2 cycles: MEM lasts 3 cycles with ReadControl=3 held. WB follows with reg_wr=1, wb_sel=2; total 6 cycles.
- sw (funct3=2): WriteControl=3 in one MEM cycle together with pc_wr=1. reg_wr stays 0; the next cycle is FETCH.
- bne: EXEC has br_type=2, ImmSrc=2, pc_wr=1; 2-cycle latency. jal: br_type=7, wb_sel=0, reg_wr=1 in WB.
- opcode 0x7F: TRAP after FETCH, halted=1, all controls 0, and stays there for 100 cycles. rst then returns to FETCH with instret=0.
- rst asserted during MEM of a store while mem_ready=0, then mem_ready=1: WriteControl=0 and pc_wr=0 throughout; state is FETCH after rst falls.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// RV32I multicycle control sequencer: FETCH/EXEC/MEM/WB with illegal-op trap.
// Drives every datapath control input from instruction fields latched in FETCH.
module multicycle_control_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             mem_ready,
    output logic             pc_wr,
    output logic             reg_wr,
    output logic             sel_A,
    output logic             sel_B,
    output logic [1:0]       wb_sel,
    output logic [2:0]       ImmSrc,
    output logic [3:0]       alu_op,
    output logic [2:0]       br_type,
    output logic [2:0]       ReadControl,
    output logic [2:0]       WriteControl,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, TRAP} state_t;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LD    = 7'h03;
    localparam logic [6:0] OP_ST    = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;

    state_t     state, state_nxt;
    logic [6:0] op_q;
    logic [2:0] f3_q;
    logic       alt_q;
    logic       unused_f7;

    // Only funct7[5] (sub/sra/srai) carries meaning in RV32I.
    assign unused_f7 = ^{funct7[6], funct7[4:0]};

    logic is_r, is_i, is_ld, is_st, is_br;
    logic is_lui, is_auipc, is_jal, is_jalr;
    logic op_ok, f3_ok, mem_done, act;

    assign is_r     = op_q == OP_R;
    assign is_i     = op_q == OP_I;
    assign is_ld    = op_q == OP_LD;
    assign is_st    = op_q == OP_ST;
    assign is_br    = op_q == OP_BR;
    assign is_lui   = op_q == OP_LUI;
    assign is_auipc = op_q == OP_AUIPC;
    assign is_jal   = op_q == OP_JAL;
    assign is_jalr  = op_q == OP_JALR;

    assign op_ok = opcode inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR,
                                  OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    assign mem_done = mem_ready || !MEM_WAIT_EN;

    always_comb begin
        f3_ok = 1'b1;
        if (is_ld) f3_ok = !(f3_q inside {3'd3, 3'd6, 3'd7});
        if (is_st) f3_ok = f3_q < 3'd3;
        if (is_br) f3_ok = !(f3_q inside {3'd2, 3'd3});
    end

    logic [3:0] alu_f3;

    always_comb begin
        alu_f3 = 4'd0;
        unique case (f3_q)
            3'd0: alu_f3 = (is_r && alt_q) ? 4'd1 : 4'd0;
            3'd1: alu_f3 = 4'd2;
            3'd2: alu_f3 = 4'd3;
            3'd3: alu_f3 = 4'd4;
            3'd4: alu_f3 = 4'd5;
            3'd5: alu_f3 = alt_q ? 4'd7 : 4'd6;
            3'd6: alu_f3 = 4'd8;
            3'd7: alu_f3 = 4'd9;
        endcase
    end

    logic       d_sel_a, d_sel_b;
    logic [1:0] d_wb;
    logic [2:0] d_imm, d_br, d_rc, d_wc;
    logic [3:0] d_alu;

    always_comb begin
        d_sel_a = 1'b0;
        d_sel_b = 1'b0;
        d_wb    = 2'd0;
        d_imm   = 3'd0;
        d_alu   = 4'd0;
        d_br    = 3'd0;
        d_rc    = 3'd0;
        d_wc    = 3'd0;
        unique case (1'b1)
            is_r: begin
                d_sel_a = 1'b1;
                d_wb    = 2'd1;
                d_alu   = alu_f3;
            end
            is_i: begin
                d_sel_a = 1'b1;
                d_sel_b = 1'b1;
                d_wb    = 2'd1;
                d_alu   = alu_f3;
            end
            is_ld: begin
                d_sel_a = 1'b1;
                d_sel_b = 1'b1;
                d_wb    = 2'd2;
                d_rc    = f3_q[2] ? f3_q : f3_q + 3'd1;
            end
            is_st: begin
                d_sel_a = 1'b1;
                d_sel_b = 1'b1;
                d_imm   = 3'd1;
                d_wc    = f3_q + 3'd1;
            end
            is_br: begin
                d_sel_b = 1'b1;
                d_imm   = 3'd2;
                // 000/001 -> 1/2, 100..111 -> 3..6
                d_br    = f3_q[2] ? f3_q - 3'd1 : f3_q + 3'd1;
            end
            is_lui: begin
                d_sel_b = 1'b1;
                d_imm   = 3'd3;
                d_alu   = 4'd10;
                d_wb    = 2'd1;
            end
            is_auipc: begin
                d_sel_b = 1'b1;
                d_imm   = 3'd3;
                d_wb    = 2'd1;
            end
            is_jal: begin
                d_sel_b = 1'b1;
                d_imm   = 3'd4;
                d_br    = 3'd7;
            end
            is_jalr: begin
                d_sel_a = 1'b1;
                d_sel_b = 1'b1;
                d_br    = 3'd7;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        act          = 1'b0;
        pc_wr        = 1'b0;
        reg_wr       = 1'b0;
        ReadControl  = 3'd0;
        WriteControl = 3'd0;
        halted       = 1'b0;
        unique case (state)
            FETCH: state_nxt = op_ok ? EXEC : TRAP;
            EXEC: begin
                if (!f3_ok) begin
                    state_nxt = TRAP;
                end else begin
                    act = 1'b1;
                    if (is_br) begin
                        pc_wr     = 1'b1;
                        state_nxt = FETCH;
                    end else if (is_ld || is_st) begin
                        state_nxt = MEM;
                    end else begin
                        state_nxt = WB;
                    end
                end
            end
            MEM: begin
                act         = 1'b1;
                ReadControl = d_rc;
                if (mem_done) begin
                    if (is_st) begin
                        WriteControl = d_wc;
                        pc_wr        = 1'b1;
                        state_nxt    = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end
            end
            WB: begin
                act         = 1'b1;
                ReadControl = d_rc;
                reg_wr      = 1'b1;
                pc_wr       = 1'b1;
                state_nxt   = FETCH;
            end
            TRAP: halted = 1'b1;
            default: state_nxt = FETCH;
        endcase
    end

    assign sel_A   = act && d_sel_a;
    assign sel_B   = act && d_sel_b;
    assign wb_sel  = act ? d_wb  : 2'd0;
    assign ImmSrc  = act ? d_imm : 3'd0;
    assign alu_op  = act ? d_alu : 4'd0;
    assign br_type = act ? d_br  : 3'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            op_q    <= 7'd0;
            f3_q    <= 3'd0;
            alt_q   <= 1'b0;
            instret <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH) begin
                op_q  <= opcode;
                f3_q  <= funct3;
                alt_q <= funct7[5];
            end
            if (pc_wr) instret <= instret + CNT_W'(1);
        end
    end
endmodule
